// File: rtl/crc32_stream.sv
// rtl/crc32_stream.sv - streaming CRC-32 (reflected) engine with byte count; optional residue check under CRC32_STREAM_CHECK_EN
module crc32_stream #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [31:0] CRC_POLY   = 32'hEDB88320,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter int          KEEP_WIDTH = (DATA_WIDTH == 4) ? 1 : DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic                  in_abort,
  output logic [31:0]           crc_state,
  output logic                  out_valid,
  output logic [31:0]           out_crc,
  output logic [15:0]           out_len,
  output logic                  out_ok
);

  // A "unit" is a byte, or a nibble when the beat itself is a nibble.
  localparam int          UNIT_W    = (DATA_WIDTH == 4) ? 4 : 8;
  localparam int          NUM_UNITS = DATA_WIDTH / UNIT_W;
  // Nibble builds count nibbles, so they need one extra bit before halving.
  localparam logic [16:0] CNT_MAX   = (DATA_WIDTH == 4) ? 17'h1FFFF : 17'h0FFFF;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state, state_next;
  logic [16:0]           cnt, cnt_next, cnt_fold;
  logic [17:0]           cnt_sum;
  logic [31:0]           crc_next, crc_fold;
  logic [KEEP_WIDTH-1:0] keep_eff;
  logic [2:0]            n_units;
  logic                  result;

  // Fold the enabled units of this beat into the register, lowest unit and bit first
  always_comb begin
    logic run;
    logic fb;
    run      = 1'b1;
    fb       = 1'b0;
    crc_fold = crc_state;
    n_units  = '0;
    // keep only matters on the last beat; an empty mask there means a full beat
    keep_eff = (in_last && (in_keep != '0)) ? in_keep : '1;
    for (int u = 0; u < NUM_UNITS; u++) begin
      // stop at the first cleared keep bit so a ragged mask never skips ahead
      run = run & keep_eff[u];
      if (run) begin
        n_units = n_units + 3'd1;
        for (int b = 0; b < UNIT_W; b++) begin
          fb       = crc_fold[0] ^ in_data[u*UNIT_W + b];
          crc_fold = {1'b0, crc_fold[31:1]} ^ (fb ? CRC_POLY : 32'h0);
        end
      end
    end
    cnt_sum  = {1'b0, cnt} + {15'd0, n_units};
    cnt_fold = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[16:0];
  end

  // Next state, register/counter update and result strobe
  always_comb begin
    state_next = state;
    crc_next   = crc_state;
    cnt_next   = cnt;
    result     = 1'b0;
    if (in_abort) begin
      state_next = IDLE;
      crc_next   = CRC_INIT;
      cnt_next   = '0;
    end else if (in_valid) begin
      if (in_last) begin
        // preset on the capturing edge so the next frame can start immediately
        result     = 1'b1;
        state_next = IDLE;
        crc_next   = CRC_INIT;
        cnt_next   = '0;
      end else begin
        state_next = ACTIVE;
        crc_next   = crc_fold;
        cnt_next   = cnt_fold;
      end
    end
  end

  // State, running register and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      crc_state <= CRC_INIT;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_crc   <= '0;
      out_len   <= '0;
    end else begin
      state     <= state_next;
      crc_state <= crc_next;
      cnt       <= cnt_next;
      out_valid <= result;
      if (result) begin
        out_crc <= ~crc_fold;
        out_len <= (DATA_WIDTH == 4) ? cnt_fold[16:1] : cnt_fold[15:0];
      end
    end
  end

`ifdef CRC32_STREAM_CHECK_EN
  // Good-frame residue of the reflected CRC-32 when the FCS is folded in too
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  // Residue comparator, captured alongside the other result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ok <= 1'b0;
    end else if (result) begin
      out_ok <= (crc_fold == RESIDUE);
    end
  end
`else
  assign out_ok = 1'b0;
`endif

endmodule
